// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single-ported data memory between the CPU load/store port and
//   an external port (loader / DMA / debug). One beat is granted per cycle.
//   Ties are broken round-robin. The external port may take at most MAX_BURST
//   consecutive beats while the CPU is waiting. A waiting CPU sees cpu_stall.
//
//   Optional feature macro: DMEM_ARB_STATS_EN
//     defined     -> stat_cpu_gnt / stat_ext_gnt / stat_conflict count activity
//     not defined -> stat_* tied to zero, no counter flops
//
// Ports
//   clk, reset                       rising-edge clock, async active-low reset
//   cpu_req/we/addr/wdata            CPU request (level, held until granted)
//   cpu_stall                        cpu_req & !cpu grant (combinational)
//   cpu_rdata, cpu_rvalid            CPU read return, 1 cycle after grant
//   ext_req/we/addr/wdata            external request, same rules as the CPU
//   ext_gnt                          external beat accepted this cycle
//   ext_rdata, ext_rvalid            external read return, 1 cycle after grant
//   mem_we/addr/wdata, mem_rdata     synchronous-read memory interface
//   stat_cpu_gnt/ext_gnt/conflict    32-bit activity counters
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic [DW-1:0] ext_rdata,
    output logic          ext_rvalid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [31:0]   stat_cpu_gnt,
    output logic [31:0]   stat_ext_gnt,
    output logic [31:0]   stat_conflict
);

    localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_EXT = 1'b1
    } owner_e;

    owner_e        last_owner_r;
    logic [BW-1:0] burst_cnt_r;
    logic          gnt_cpu_s;
    logic          gnt_ext_s;
    logic          mem_we_s;
    logic          cpu_rvalid_r;
    logic          ext_rvalid_r;
    logic [DW-1:0] cpu_rdata_r;
    logic [DW-1:0] ext_rdata_r;

    // Grant decision: single beat per cycle, round-robin on ties, burst cap for EXT
    always_comb begin
        gnt_cpu_s = 1'b0;
        gnt_ext_s = 1'b0;
        if (cpu_req && ext_req) begin
            if (burst_cnt_r == BURST_MAX) begin
                gnt_cpu_s = 1'b1;
            end else if (last_owner_r == OWNER_EXT) begin
                gnt_cpu_s = 1'b1;
            end else begin
                gnt_ext_s = 1'b1;
            end
        end else if (cpu_req) begin
            gnt_cpu_s = 1'b1;
        end else if (ext_req) begin
            gnt_ext_s = 1'b1;
        end else begin
            gnt_cpu_s = 1'b0;
            gnt_ext_s = 1'b0;
        end
    end

    // Memory-side mux: idle cycles present the CPU address with no write
    always_comb begin
        mem_we_s  = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (gnt_ext_s) begin
            mem_we_s  = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end else if (gnt_cpu_s) begin
            mem_we_s  = cpu_we;
        end else begin
            mem_we_s  = 1'b0;
        end
    end

    // Write strobe is suppressed while reset is held so no stray write can land
    assign mem_we    = mem_we_s & reset;
    assign cpu_stall = cpu_req & ~gnt_cpu_s;
    assign ext_gnt   = gnt_ext_s;

    // Arbitration history: last owner and EXT beats taken while the CPU waits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner_r <= OWNER_EXT;
            burst_cnt_r  <= {BW{1'b0}};
        end else if (gnt_cpu_s) begin
            last_owner_r <= OWNER_CPU;
            burst_cnt_r  <= {BW{1'b0}};
        end else if (gnt_ext_s) begin
            last_owner_r <= OWNER_EXT;
            if (cpu_req && (burst_cnt_r != BURST_MAX)) begin
                burst_cnt_r <= burst_cnt_r + BW'(1);
            end
        end else begin
            burst_cnt_r <= {BW{1'b0}};
        end
    end

    // Read-return tracking: valid one cycle after a granted read; data held afterwards
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rvalid_r <= 1'b0;
            ext_rvalid_r <= 1'b0;
            cpu_rdata_r  <= {DW{1'b0}};
            ext_rdata_r  <= {DW{1'b0}};
        end else begin
            cpu_rvalid_r <= gnt_cpu_s & ~cpu_we;
            ext_rvalid_r <= gnt_ext_s & ~ext_we;
            if (cpu_rvalid_r) begin
                cpu_rdata_r <= mem_rdata;
            end
            if (ext_rvalid_r) begin
                ext_rdata_r <= mem_rdata;
            end
        end
    end

    // The memory already registers its read data, so in the rvalid cycle the
    // word is forwarded directly; the hold register keeps it stable afterwards.
    assign cpu_rvalid = cpu_rvalid_r;
    assign ext_rvalid = ext_rvalid_r;
    assign cpu_rdata  = cpu_rvalid_r ? mem_rdata : cpu_rdata_r;
    assign ext_rdata  = ext_rvalid_r ? mem_rdata : ext_rdata_r;

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_cpu_r;
    logic [31:0] stat_ext_r;
    logic [31:0] stat_conf_r;

    // Activity counters, wrapping at 2^32
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_cpu_r  <= 32'd0;
            stat_ext_r  <= 32'd0;
            stat_conf_r <= 32'd0;
        end else begin
            if (gnt_cpu_s) begin
                stat_cpu_r <= stat_cpu_r + 32'd1;
            end
            if (gnt_ext_s) begin
                stat_ext_r <= stat_ext_r + 32'd1;
            end
            if (cpu_req && ext_req) begin
                stat_conf_r <= stat_conf_r + 32'd1;
            end
        end
    end

    assign stat_cpu_gnt  = stat_cpu_r;
    assign stat_ext_gnt  = stat_ext_r;
    assign stat_conflict = stat_conf_r;
`else
    assign stat_cpu_gnt  = 32'd0;
    assign stat_ext_gnt  = 32'd0;
    assign stat_conflict = 32'd0;
`endif

endmodule
